// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit in front of the single-cycle core.
// One outstanding imem request; captured word held on a valid/ready output.
module ifu_fetch #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    input  logic        redirect,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  inst_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DRAIN,
        HOLD
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] inst_q;
    logic [31:0] inst_d;
    logic [31:0] pc_q;
    logic [1:0]  fault_q;
    logic [1:0]  fault_d;
    logic [31:0] count_q;
    logic        cap_pc;
    logic        cap_inst;
    logic        consume;
    logic        aligned;

    assign aligned        = (fetch_pc[1:0] == 2'b00);
    assign imem_req_valid = (state_q == REQ) && aligned && !redirect;
    assign imem_req_addr  = fetch_pc;
    assign inst_valid     = (state_q == HOLD);
    assign inst           = inst_q;
    assign inst_pc        = pc_q;
    assign inst_fault     = fault_q;
    assign fetch_count    = count_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and capture controls.
    always_comb begin
        state_d  = state_q;
        cap_pc   = 1'b0;
        cap_inst = 1'b0;
        consume  = 1'b0;
        inst_d   = inst_q;
        fault_d  = fault_q;
        unique case (state_q)
            REQ: begin
                if (!redirect) begin
                    if (!aligned) begin
                        state_d  = HOLD;
                        cap_pc   = 1'b1;
                        cap_inst = 1'b1;
                        inst_d   = NOP_INST;
                        fault_d  = 2'b01;
                    end else if (imem_req_ready) begin
                        state_d = WAIT;
                        cap_pc  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect) begin
                        state_d = REQ;
                    end else begin
                        state_d  = HOLD;
                        cap_inst = 1'b1;
                        inst_d   = imem_rsp_err ? NOP_INST
                                                : imem_rsp_data;
                        fault_d  = imem_rsp_err ? 2'b10 : 2'b00;
                    end
                end else if (redirect) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    state_d = REQ;
                    consume = 1'b1;
                end else if (redirect) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    // Output holding registers and consumed-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q  <= NOP_INST;
            pc_q    <= 32'h0;
            fault_q <= 2'b00;
            count_q <= 32'h0;
        end else begin
            if (cap_pc) begin
                pc_q <= fetch_pc;
            end
            if (cap_inst) begin
                inst_q  <= inst_d;
                fault_q <= fault_d;
            end
            if (consume) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed self-checking bench for ifu_fetch.
// Inputs change and outputs are sampled on the falling edge.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        redirect;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_fault;
    logic [31:0] fetch_count;

    int n_chk  = 0;
    int n_fail = 0;
    int req_cnt = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_pc       (fetch_pc),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req_valid && imem_req_ready) begin
            req_cnt <= req_cnt + 1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch_pc = 32'h80000000;
        redirect = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        imem_rsp_err = 1'b0;
        inst_ready = 1'b0;
        step();
        step();
        n_chk++;
        if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0
            || inst_fault !== 2'b00 || fetch_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: v=%b i=%h pc=%h f=%b c=%0d want 0/%h/0/0/0",
                     inst_valid, inst, inst_pc, inst_fault, fetch_count, NOP);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        #1;
        n_chk++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000000) begin
            n_fail++;
            $display("FAIL basic_req: v=%b a=%h want 1/80000000",
                     imem_req_valid, imem_req_addr);
        end
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h00100093;
        #1;
        n_chk++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_wait: iv=%b rv=%b want 0/0",
                     inst_valid, imem_req_valid);
        end
        step();
        imem_rsp_valid = 1'b0;
        n_chk++;
        if (inst_valid !== 1'b1 || inst !== 32'h00100093
            || inst_pc !== 32'h80000000 || inst_fault !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_hold: v=%b i=%h pc=%h f=%b",
                     inst_valid, inst, inst_pc, inst_fault);
        end
        step();
        inst_ready = 1'b0;
        n_chk++;
        if (inst_valid !== 1'b0 || fetch_count !== 32'd1) begin
            n_fail++;
            $display("FAIL basic_count: v=%b c=%0d want 0/1",
                     inst_valid, fetch_count);
        end
    endtask

    task automatic test_backpressure();
        int r0;
        r0 = req_cnt;
        fetch_pc = 32'h80000004;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_chk++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000004) begin
                n_fail++;
                $display("FAIL bp_req_stall%0d: v=%b a=%h", k,
                         imem_req_valid, imem_req_addr);
            end
            step();
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_chk++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_wait%0d: rv=%b iv=%b want 0/0", k,
                         imem_req_valid, inst_valid);
            end
            step();
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h00200113;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'hFFFFFFFF;
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (inst_valid !== 1'b1 || inst !== 32'h00200113
                || inst_pc !== 32'h80000004) begin
                n_fail++;
                $display("FAIL bp_hold%0d: v=%b i=%h pc=%h", k,
                         inst_valid, inst, inst_pc);
            end
            step();
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        n_chk++;
        if (fetch_count !== 32'd2 || req_cnt - r0 !== 1) begin
            n_fail++;
            $display("FAIL bp_count: c=%0d reqs=%0d want 2/1",
                     fetch_count, req_cnt - r0);
        end
    endtask

    task automatic test_misaligned();
        fetch_pc = 32'h80000002;
        imem_req_ready = 1'b1;
        #1;
        n_chk++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_req0: v=%b want 0", imem_req_valid);
        end
        step();
        n_chk++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1
            || inst !== NOP || inst_fault !== 2'b01
            || inst_pc !== 32'h80000002) begin
            n_fail++;
            $display("FAIL mis_hold: rv=%b iv=%b i=%h f=%b pc=%h",
                     imem_req_valid, inst_valid, inst, inst_fault, inst_pc);
        end
        imem_req_ready = 1'b0;
        inst_ready = 1'b1;
        fetch_pc = 32'h80000008;
        step();
        inst_ready = 1'b0;
        n_chk++;
        if (fetch_count !== 32'd3) begin
            n_fail++;
            $display("FAIL mis_count: c=%0d want 3", fetch_count);
        end
    endtask

    task automatic test_access_error();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err = 1'b1;
        imem_rsp_data = 32'h12345678;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err = 1'b0;
        n_chk++;
        if (inst_valid !== 1'b1 || inst !== NOP || inst_fault !== 2'b10
            || inst_pc !== 32'h80000008) begin
            n_fail++;
            $display("FAIL err_hold: v=%b i=%h f=%b pc=%h",
                     inst_valid, inst, inst_fault, inst_pc);
        end
        inst_ready = 1'b1;
        fetch_pc = 32'h8000000C;
        step();
        inst_ready = 1'b0;
        n_chk++;
        if (fetch_count !== 32'd4) begin
            n_fail++;
            $display("FAIL err_count: c=%0d want 4", fetch_count);
        end
    endtask

    task automatic test_redirect_squash();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        fetch_pc = 32'h80000100;
        n_chk++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sq_drain: rv=%b iv=%b want 0/0",
                     imem_req_valid, inst_valid);
        end
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEADBEEF;
        step();
        imem_rsp_valid = 1'b0;
        n_chk++;
        if (inst_valid !== 1'b0 || inst !== NOP) begin
            n_fail++;
            $display("FAIL sq_stale: v=%b i=%h want 0/%h",
                     inst_valid, inst, NOP);
        end
        n_chk++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000100) begin
            n_fail++;
            $display("FAIL sq_newreq: v=%b a=%h want 1/80000100",
                     imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h00300193;
        step();
        imem_rsp_valid = 1'b0;
        n_chk++;
        if (inst_valid !== 1'b1 || inst !== 32'h00300193
            || inst_pc !== 32'h80000100) begin
            n_fail++;
            $display("FAIL sq_refetch: v=%b i=%h pc=%h",
                     inst_valid, inst, inst_pc);
        end
        inst_ready = 1'b1;
        fetch_pc = 32'h80000104;
        step();
        inst_ready = 1'b0;
        n_chk++;
        if (fetch_count !== 32'd5) begin
            n_fail++;
            $display("FAIL sq_count: c=%0d want 5", fetch_count);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEADBEEF;
        step();
        redirect = 1'b0;
        imem_rsp_valid = 1'b0;
        fetch_pc = 32'h80000200;
        #1;
        n_chk++;
        if (inst_valid !== 1'b0 || inst !== 32'h00300193
            || imem_req_valid !== 1'b1
            || imem_req_addr !== 32'h80000200) begin
            n_fail++;
            $display("FAIL sq_coinc: iv=%b i=%h rv=%b a=%h",
                     inst_valid, inst, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_hold_redirect();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h00400213;
        step();
        imem_rsp_valid = 1'b0;
        redirect = 1'b1;
        inst_ready = 1'b1;
        step();
        redirect = 1'b0;
        inst_ready = 1'b0;
        n_chk++;
        if (inst_valid !== 1'b0 || fetch_count !== 32'd6) begin
            n_fail++;
            $display("FAIL hr_both: v=%b c=%0d want 0/6",
                     inst_valid, fetch_count);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        n_chk++;
        if (inst_valid !== 1'b0 || fetch_count !== 32'd6) begin
            n_fail++;
            $display("FAIL hr_redir: v=%b c=%0d want 0/6",
                     inst_valid, fetch_count);
        end
    endtask

    task automatic test_wrap_reset();
        dut.count_q = 32'hFFFFFFFF;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h00500293;
        step();
        imem_rsp_valid = 1'b0;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        n_chk++;
        if (fetch_count !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap: c=%h want 00000000", fetch_count);
        end
        fetch_pc = 32'h80000300;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hABCDEF01;
        step();
        imem_rsp_valid = 1'b0;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        fetch_pc = 32'h80000302;
        step();
        n_chk++;
        if (inst_valid !== 1'b1 || fetch_count !== 32'd1
            || inst_fault !== 2'b01 || inst_pc !== 32'h80000302) begin
            n_fail++;
            $display("FAIL pre_rst_hold: v=%b c=%0d f=%b pc=%h",
                     inst_valid, fetch_count, inst_fault, inst_pc);
        end
        #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0
            || inst_fault !== 2'b00 || fetch_count !== 32'h0) begin
            n_fail++;
            $display("FAIL async_rst: v=%b i=%h pc=%h f=%b c=%0d",
                     inst_valid, inst, inst_pc, inst_fault, fetch_count);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_misaligned();
        test_access_error();
        test_redirect_squash();
        test_hold_redirect();
        test_wrap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
